counter_nch: RTL and testbench
==============================

Name: counter_nch

Overview:
- Parametrised N-channel programmable timer/counter for the MIO peripheral space.
- Successor to the fixed 3-channel counter. Adds a configurable channel count and width, per-channel modes (one-shot, periodic, square wave), per-channel interrupt pending/enable and an aggregated irq line.
- Sits beside the bus decoder: the CPU writes reload and control words through the counter write strobe, and reads back the selected channel's count.
- Count rates come from clock-divider taps on the tick vector.

Parameters:
- NCH, 4, number of channels (1..8).
- CW, 32, counter width per channel (8..32).
- SELW, 2, channel-select width; must equal clog2(NCH), minimum 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  NCH  per-channel count source (divider bits); a rising edge is one count event.
- counter_we  in  1  write strobe, one clk cycle.
- counter_sel  in  SELW  target channel for writes and readback.
- counter_reg  in  1  write target: 0 = reload value, 1 = control word.
- counter_val  in  32  write data; the reload value uses bits [CW-1:0].
- counter_out  out  32  current count of channel counter_sel, zero-extended.
- cnt_out  out  NCH  per-channel output level.
- irq  out  1  OR over all channels of (pending & irq_en).

Behaviour:
- Reset values:
  - count, reload, ctrl, cnt_out, pending and tick_q are all 0.
  - counter_out is 0 and irq is 0.
- Control word bits:
  - [0] en.
  - [2:1] mode: 00 one-shot, 01 periodic, 10 square, 11 hold.
  - [3] irq_en.
  - [4] clr_pend: write action only, not stored.
  - Other bits are ignored.
- Event detect:
  - tick_q <= tick every cycle, regardless of enable.
  - event[i] = tick[i] & ~tick_q[i].
  - The count and output update on the clk edge after the cycle in which the event is detected.
- Events are processed only when en=1 and mode!=11. Otherwise the count holds and events are dropped.
- Reload write:
  - reload <= counter_val[CW-1:0], count <= same value, cnt_out <= 0.
  - Takes effect on the next edge.
- Control write:
  - ctrl is updated.
  - If the mode field changes, cnt_out <= 0 and the count is unchanged.
  - clr_pend=1 clears that channel's pending bit.
- One-shot mode:
  - On an event with count>1: count-1.
  - On an event with count==1: count <= 0, cnt_out <= 1, pending <= 1.
  - count==0: events are ignored and cnt_out stays at its current level until the next reload write.
- Periodic mode:
  - On an event with count>1: count-1.
  - On an event with count<=1: count <= reload, cnt_out high for exactly one clk cycle, pending <= 1.
  - Period = max(reload,1) events.
- Square mode:
  - On an event with count>1: count-1.
  - On an event with count<=1: count <= reload and cnt_out toggles.
  - pending <= 1 only on the 0->1 toggle.
  - Full period = 2*max(reload,1) events.
- Simultaneous events:
  - Reload write and event on the same channel in the same cycle: the write wins and the event is lost.
  - clr_pend and a pending-set in the same cycle: set wins, pending=1.
  - Control write disabling a channel in the same cycle as an event: the event is dropped.
- Selects outside the channel range (counter_sel >= NCH): writes are ignored and counter_out = 0.
- counter_out and irq are combinational from registered state, zero latency.
- Reset asserted mid-count: all state returns to the reset values immediately, with no pending glitch after release.

Decomposition:
- Package counter_pkg:
  - Mode constants MODE_ONESHOT, MODE_PERIODIC, MODE_SQUARE, MODE_HOLD.
  - Control bit positions CTRL_EN, CTRL_MODE_LO, CTRL_MODE_HI, CTRL_IRQEN, CTRL_CLRPEND.
- Sub-module counter_chan:
  - One channel: edge detect, count, reload, ctrl, out, pending.
  - Instantiated NCH times via generate.
- Top level: write decode, readback mux and irq OR.

Test Plan:
- Reset mid-operation: assert rst while channel 1 is counting in periodic mode with reload 5 → count=0, cnt_out=0, irq=0 immediately; after release no events occur until ctrl is rewritten.
- One-shot: channel 0, reload 3, ctrl=0x09 (en, one-shot, irq_en), three tick[0] rising edges:
  - counter_out reads 2, 1, 0.
  - cnt_out[0]=1 and irq=1 one cycle after the third event.
  - A fourth edge causes no change.
- Periodic: channel 2, reload 4, ctrl=0x03, 12 edges → cnt_out[2] pulses exactly 3 times, each one clk cycle wide; pending set.
- Square: channel 3, reload 2, ctrl=0x05, 8 edges → cnt_out[3] toggles after edges 2, 4, 6, 8 (two full periods); pending set only on the rising toggles.
- Collision 1: reload write of 7 in the same cycle as a tick edge → counter_out=7 next cycle.
- Collision 2: clr_pend in the same cycle as a pending-set → pending stays 1.
- Out-of-range select: with NCH=3, counter_sel=3 → the write is ignored and counter_out=0.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the N-channel timer/counter.
//   mode_e      : per-channel counting mode held in control bits [2:1]
//   CTRL_*      : bit positions inside the control word
//   CTRL_W      : number of control bits actually stored per channel
//   ctrl_mode() : extracts the mode field from a stored control word
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IRQEN   = 3;
    localparam int CTRL_CLRPEND = 4;

    // clr_pend is a write action only, so just en/mode/irq_en are stored
    localparam int CTRL_W = 4;

    function automatic mode_e ctrl_mode(input logic [CTRL_W-1:0] ctrl);
        return mode_e'(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);
    endfunction

endpackage

// File: rtl/counter_chan.sv
// counter_chan: one timer channel.
//   clk, rst    : system clock, asynchronous active-high reset
//   tick        : count source; each rising edge is one count event
//   wr_reload   : load reload_val into reload and count this cycle
//   wr_ctrl     : load ctrl_val into the control register this cycle
//   reload_val  : reload data
//   ctrl_val    : control data including the clr_pend action bit
//   count       : current count
//   cnt_out     : channel output level (registered)
//   irq_req     : pending & irq_en
module counter_chan
    import counter_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  wr_reload,
    input  logic                  wr_ctrl,
    input  logic [CW-1:0]         reload_val,
    input  logic [CTRL_CLRPEND:0] ctrl_val,
    output logic [CW-1:0]         count,
    output logic                  cnt_out,
    output logic                  irq_req
);

    logic              tick_q_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     reload_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic              out_r;
    logic              pending_r;

    logic              event_s;
    logic [CTRL_W-1:0] ctrl_nxt_s;
    mode_e             mode_nxt_s;
    logic              mode_chg_s;
    logic              active_s;
    logic              pend_clr_s;
    logic              pend_set_s;
    logic              out_nxt_s;
    logic [CW-1:0]     count_nxt_s;

    // Event detect and effective control word for this cycle
    always_comb begin
        event_s = tick & ~tick_q_r;
        if (wr_ctrl) begin
            ctrl_nxt_s = ctrl_val[CTRL_W-1:0];
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
        mode_nxt_s = ctrl_mode(ctrl_nxt_s);
        mode_chg_s = wr_ctrl && (mode_nxt_s != ctrl_mode(ctrl_r));
        // A reload write or a mode change swallows any event in the same
        // cycle; a control write that disables the channel drops it too.
        active_s   = ctrl_nxt_s[CTRL_EN] && (mode_nxt_s != MODE_HOLD)
                     && !mode_chg_s && !wr_reload;
        pend_clr_s = wr_ctrl && ctrl_val[CTRL_CLRPEND];
    end

    // Next count, output level and pending-set request
    always_comb begin
        count_nxt_s = count_r;
        out_nxt_s   = out_r;
        pend_set_s  = 1'b0;
        if (wr_reload) begin
            count_nxt_s = reload_val;
            out_nxt_s   = 1'b0;
        end else if (mode_chg_s) begin
            out_nxt_s   = 1'b0;
        end else if (event_s && active_s) begin
            case (mode_nxt_s)
                MODE_ONESHOT: begin
                    if (count_r > CW'(1)) begin
                        count_nxt_s = count_r - CW'(1);
                    end else if (count_r == CW'(1)) begin
                        count_nxt_s = '0;
                        out_nxt_s   = 1'b1;
                        pend_set_s  = 1'b1;
                    end else begin
                        // expired: stays put until the next reload write
                        count_nxt_s = count_r;
                    end
                end
                MODE_PERIODIC: begin
                    if (count_r > CW'(1)) begin
                        count_nxt_s = count_r - CW'(1);
                        out_nxt_s   = 1'b0;
                    end else begin
                        count_nxt_s = reload_r;
                        out_nxt_s   = 1'b1;
                        pend_set_s  = 1'b1;
                    end
                end
                MODE_SQUARE: begin
                    if (count_r > CW'(1)) begin
                        count_nxt_s = count_r - CW'(1);
                    end else begin
                        count_nxt_s = reload_r;
                        out_nxt_s   = ~out_r;
                        pend_set_s  = ~out_r;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end else if (mode_nxt_s == MODE_PERIODIC) begin
            // the periodic pulse lasts exactly one clock
            out_nxt_s = 1'b0;
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q_r  <= 1'b0;
            count_r   <= '0;
            reload_r  <= '0;
            ctrl_r    <= '0;
            out_r     <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            tick_q_r <= tick;
            if (wr_reload) begin
                reload_r <= reload_val;
            end
            if (wr_ctrl) begin
                ctrl_r <= ctrl_val[CTRL_W-1:0];
            end
            count_r   <= count_nxt_s;
            out_r     <= out_nxt_s;
            // a set in the same cycle as a clear wins
            pending_r <= pend_set_s | (pending_r & ~pend_clr_s);
        end
    end

    assign count   = count_r;
    assign cnt_out = out_r;
    assign irq_req = pending_r & ctrl_r[CTRL_IRQEN];

endmodule

// File: rtl/counter_nch.sv
// counter_nch: N-channel programmable timer/counter.
//   clk, rst    : system clock, asynchronous active-high reset
//   tick        : per-channel count sources (rising edge = one event)
//   counter_we  : one-cycle write strobe
//   counter_sel : channel for writes and readback
//   counter_reg : 0 = reload value, 1 = control word
//   counter_val : write data
//   counter_out : count of the selected channel, zero-extended (0 if out of range)
//   cnt_out     : per-channel output levels
//   irq         : OR of pending & irq_en over all channels
module counter_nch
    import counter_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CW   = 32,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  tick,
    input  logic            counter_we,
    input  logic [SELW-1:0] counter_sel,
    input  logic            counter_reg,
    input  logic [31:0]     counter_val,
    output logic [31:0]     counter_out,
    output logic [NCH-1:0]  cnt_out,
    output logic            irq
);

    logic [CW-1:0]  count_s [NCH];
    logic [NCH-1:0] wr_reload_s;
    logic [NCH-1:0] wr_ctrl_s;
    logic [NCH-1:0] irq_req_s;
    logic           unused_val_s;

    // only the low CW bits and the low control bits are meaningful
    assign unused_val_s = ^counter_val;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // selects at or beyond NCH match no channel, so those writes vanish
        assign wr_reload_s[i] = counter_we & ~counter_reg & (counter_sel == SELW'(i));
        assign wr_ctrl_s[i]   = counter_we &  counter_reg & (counter_sel == SELW'(i));

        counter_chan #(
            .CW(CW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick[i]),
            .wr_reload  (wr_reload_s[i]),
            .wr_ctrl    (wr_ctrl_s[i]),
            .reload_val (counter_val[CW-1:0]),
            .ctrl_val   (counter_val[CTRL_CLRPEND:0]),
            .count      (count_s[i]),
            .cnt_out    (cnt_out[i]),
            .irq_req    (irq_req_s[i])
        );
    end

    // Readback mux; out-of-range selects read as zero
    always_comb begin
        counter_out = 32'd0;
        for (int i = 0; i < NCH; i++) begin
            if (counter_sel == SELW'(i)) begin
                counter_out = 32'(count_s[i]);
            end else begin
                counter_out = counter_out;
            end
        end
    end

    assign irq = |irq_req_s;

endmodule

// File: tb/tb_counter_nch.sv
module tb_counter_nch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  tick = 4'd0;
    logic        counter_we = 1'b0;
    logic [1:0]  counter_sel = 2'd0;
    logic        counter_reg = 1'b0;
    logic [31:0] counter_val = 32'd0;
    logic [31:0] counter_out;
    logic [3:0]  cnt_out;
    logic        irq;

    // three-channel instance for the out-of-range select case
    logic [2:0]  tick3 = 3'd0;
    logic        we3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;
    logic        reg3 = 1'b0;
    logic [31:0] val3 = 32'd0;
    logic [31:0] out3;
    logic [2:0]  cnt3;
    logic        irq3;

    counter_nch #(.NCH(4), .CW(32), .SELW(2)) dut (
        .clk(clk), .rst(rst), .tick(tick), .counter_we(counter_we),
        .counter_sel(counter_sel), .counter_reg(counter_reg),
        .counter_val(counter_val), .counter_out(counter_out),
        .cnt_out(cnt_out), .irq(irq)
    );

    counter_nch #(.NCH(3), .CW(16), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .tick(tick3), .counter_we(we3),
        .counter_sel(sel3), .counter_reg(reg3),
        .counter_val(val3), .counter_out(out3),
        .cnt_out(cnt3), .irq(irq3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic r, input logic [31:0] val);
        counter_we  = 1'b1;
        counter_sel = sel;
        counter_reg = r;
        counter_val = val;
        cyc();
        counter_we  = 1'b0;
    endtask

    task automatic tick_pulse(input int ch);
        tick[ch] = 1'b1;
        cyc();
        tick[ch] = 1'b0;
        cyc();
    endtask

    // pulse monitor for channel 2
    logic mon_on = 1'b0;
    logic prev2 = 1'b0;
    int   hi_cycles = 0;
    int   rises = 0;
    always @(negedge clk) begin
        if (mon_on) begin
            if (cnt_out[2]) hi_cycles++;
            if (cnt_out[2] && !prev2) rises++;
            prev2 = cnt_out[2];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sq_exp;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        sb_push("rst_cnt_out", 32'd0);
        sb_push("rst_irq", 32'd0);
        sb_pop(32'(cnt_out));
        sb_pop(32'(irq));
        rst = 1'b0;
        cyc();
        for (int s = 0; s < 4; s++) begin
            counter_sel = 2'(s);
            #1;
            sb_push("rst_count", 32'd0);
            sb_pop(counter_out);
        end

        // reset mid-operation on periodic channel 1
        wr(2'd1, 1'b0, 32'd5);
        wr(2'd1, 1'b1, 32'h0B);
        counter_sel = 2'd1;
        repeat (5) tick_pulse(1);
        sb_push("rm_wrap_cnt", 32'd5);
        sb_push("rm_wrap_irq", 32'd1);
        sb_pop(counter_out);
        sb_pop(32'(irq));
        tick_pulse(1);
        sb_push("rm_cnt4", 32'd4);
        sb_pop(counter_out);
        #2;
        rst = 1'b1;
        #1;
        sb_push("rm_async_cnt", 32'd0);
        sb_push("rm_async_out", 32'd0);
        sb_push("rm_async_irq", 32'd0);
        sb_pop(counter_out);
        sb_pop(32'(cnt_out));
        sb_pop(32'(irq));
        cyc();
        rst = 1'b0;
        repeat (3) tick_pulse(1);
        sb_push("rm_post_cnt", 32'd0);
        sb_push("rm_post_out", 32'd0);
        sb_push("rm_post_irq", 32'd0);
        sb_pop(counter_out);
        sb_pop(32'(cnt_out));
        sb_pop(32'(irq));

        // one-shot on channel 0
        wr(2'd0, 1'b0, 32'd3);
        wr(2'd0, 1'b1, 32'h09);
        counter_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            sb_push("os_cnt", 32'(2 - i));
            sb_push("os_out", (i == 2) ? 32'd1 : 32'd0);
            sb_push("os_irq", (i == 2) ? 32'd1 : 32'd0);
            tick[0] = 1'b1;
            cyc();
            sb_pop(counter_out);
            sb_pop(32'(cnt_out[0]));
            sb_pop(32'(irq));
            tick[0] = 1'b0;
            cyc();
        end
        tick_pulse(0);
        sb_push("os_4th_cnt", 32'd0);
        sb_push("os_4th_out", 32'd1);
        sb_pop(counter_out);
        sb_pop(32'(cnt_out[0]));
        wr(2'd0, 1'b1, 32'h19);
        sb_push("os_clr_irq", 32'd0);
        sb_pop(32'(irq));

        // periodic on channel 2
        wr(2'd2, 1'b0, 32'd4);
        wr(2'd2, 1'b1, 32'h03);
        counter_sel = 2'd2;
        hi_cycles = 0;
        rises = 0;
        prev2 = 1'b0;
        mon_on = 1'b1;
        repeat (12) tick_pulse(2);
        mon_on = 1'b0;
        sb_push("per_hi_cycles", 32'd3);
        sb_push("per_rises", 32'd3);
        sb_push("per_cnt", 32'd4);
        sb_push("per_irq_masked", 32'd0);
        sb_pop(32'(hi_cycles));
        sb_pop(32'(rises));
        sb_pop(counter_out);
        sb_pop(32'(irq));
        wr(2'd2, 1'b1, 32'h0B);
        sb_push("per_pending", 32'd1);
        sb_pop(32'(irq));
        wr(2'd2, 1'b1, 32'h1A);
        sb_push("per_clr", 32'd0);
        sb_pop(32'(irq));

        // square on channel 3
        wr(2'd3, 1'b0, 32'd2);
        wr(2'd3, 1'b1, 32'h05);
        counter_sel = 2'd3;
        sq_exp = 8'h66;
        for (int i = 0; i < 8; i++) begin
            sb_push("sq_out", 32'(sq_exp[i]));
            tick_pulse(3);
            sb_pop(32'(cnt_out[3]));
        end
        sb_push("sq_cnt", 32'd2);
        sb_pop(counter_out);
        wr(2'd3, 1'b1, 32'h1D);
        sb_push("sq_clr", 32'd0);
        sb_pop(32'(irq));
        tick_pulse(3);
        sb_push("sq_e9_irq", 32'd0);
        sb_pop(32'(irq));
        tick_pulse(3);
        sb_push("sq_rise_irq", 32'd1);
        sb_push("sq_rise_out", 32'd1);
        sb_pop(32'(irq));
        sb_pop(32'(cnt_out[3]));
        wr(2'd3, 1'b1, 32'h1D);
        tick_pulse(3);
        tick_pulse(3);
        sb_push("sq_fall_irq", 32'd0);
        sb_push("sq_fall_out", 32'd0);
        sb_pop(32'(irq));
        sb_pop(32'(cnt_out[3]));

        // collision: reload write and tick edge together
        tick[3]     = 1'b1;
        counter_we  = 1'b1;
        counter_sel = 2'd3;
        counter_reg = 1'b0;
        counter_val = 32'd7;
        sb_push("col1_cnt", 32'd7);
        cyc();
        counter_we = 1'b0;
        tick[3]    = 1'b0;
        sb_pop(counter_out);
        cyc();

        // collision: clr_pend and pending-set together
        wr(2'd3, 1'b0, 32'd1);
        tick[3]     = 1'b1;
        counter_we  = 1'b1;
        counter_reg = 1'b1;
        counter_val = 32'h1D;
        sb_push("col2_irq", 32'd1);
        sb_push("col2_out", 32'd1);
        cyc();
        counter_we = 1'b0;
        tick[3]    = 1'b0;
        sb_pop(32'(irq));
        sb_pop(32'(cnt_out[3]));
        cyc();

        // out-of-range select on the three-channel instance
        we3  = 1'b1;
        reg3 = 1'b0;
        sel3 = 2'd2;
        val3 = 32'd5;
        cyc();
        sel3 = 2'd3;
        val3 = 32'd9;
        cyc();
        we3 = 1'b0;
        #1;
        sb_push("oor_read", 32'd0);
        sb_pop(out3);
        sel3 = 2'd2;
        #1;
        sb_push("oor_ch2_kept", 32'd5);
        sb_pop(out3);
        sel3 = 2'd0;
        #1;
        sb_push("oor_ch0", 32'd0);
        sb_pop(out3);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
